// File: rtl/aes_host_if_pkg.sv
// Shared constants for the AES host front-end.
// Covers register addresses, bit positions within the host words, key-length codes and FSM states.
package aes_if_pkg;
    localparam int unsigned ADDR_IDLE   = 0;
    localparam int unsigned ADDR_CONFIG = 1;
    localparam int unsigned ADDR_KEY    = 2;
    localparam int unsigned ADDR_BLOCK  = 3;
    localparam int unsigned ADDR_STATUS = 5;
    localparam int unsigned ADDR_START  = 6;
    localparam int unsigned ADDR_RESULT = 7;

    localparam int unsigned CFG_ENCDEC_BIT = 0;
    localparam int unsigned CFG_KEYLEN_BIT = 1;

    localparam int unsigned CTRL_INIT_BIT = 0;
    localparam int unsigned CTRL_NEXT_BIT = 1;

    localparam int unsigned STS_READY_BIT = 0;
    localparam int unsigned STS_VALID_BIT = 1;
    localparam int unsigned STS_ERR_BIT   = 2;

    localparam int unsigned START_BLOCK_FULL_BIT = 0;
    localparam int unsigned START_KEY_FULL_BIT   = 1;
    localparam int unsigned START_ENCDEC_BIT     = 2;
    localparam int unsigned START_KEYLEN_BIT     = 3;

    localparam logic AES_128 = 1'b0;
    localparam logic AES_256 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_CIPHER = 2'd2
    } fsm_state_e;
endpackage

// File: rtl/aes_beat_shifter.sv
// MSB-first shift register that accepts one DIN_W-bit beat per cycle.
// It counts beats up to a limit, and any beat beyond that limit is dropped and flagged.
module aes_beat_shifter #(
    parameter int unsigned W     = 256,
    parameter int unsigned DIN_W = 16,
    parameter int unsigned CNT_W = $clog2(W / DIN_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_i,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] limit_i,
    input  logic [DIN_W-1:0] din_i,
    output logic [W-1:0]     data_o,
    output logic             full_o,
    output logic             ovf_o
);
    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next data/count; a restart beat discards the previous contents first
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        ovf_o  = 1'b0;
        if (shift_i) begin
            if (restart_i) begin
                data_d = {{(W - DIN_W){1'b0}}, din_i};
                cnt_d  = CNT_W'(1);
            end else if (cnt_q >= limit_i) begin
                ovf_o = 1'b1;
            end else begin
                data_d = {data_q[W-DIN_W-1:0], din_i};
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else begin
            ovf_o = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o = data_q;
    assign full_o = (cnt_q >= limit_i);
endmodule

// File: rtl/aes_host_if.sv
// Host register front-end for the AES core.
// It loads the key and block in beats, sequences init/next through an FSM, and streams the result back in beats.
module aes_host_if
    import aes_if_pkg::*;
#(
    parameter int unsigned DIN_W  = 16,
    parameter int unsigned DOUT_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DIN_W-1:0]  data_in,
    output logic [DOUT_W-1:0] data_out,
    output logic              core_encdec,
    output logic              core_keylen,
    output logic              core_init,
    output logic              core_next,
    output logic [255:0]      core_key,
    output logic [127:0]      core_block,
    input  logic              core_ready,
    input  logic              core_valid,
    input  logic [127:0]      core_result
);
    localparam int unsigned KB128  = 128 / DIN_W;
    localparam int unsigned KB256  = 256 / DIN_W;
    localparam int unsigned BB     = 128 / DIN_W;
    localparam int unsigned RBEATS = 128 / DOUT_W;
    localparam int unsigned KCNT_W = $clog2(KB256 + 1);
    localparam int unsigned BCNT_W = $clog2(BB + 1);
    localparam int unsigned RP_W   = $clog2(RBEATS);

    localparam logic [ADDR_W-1:0] A_CONFIG = ADDR_W'(ADDR_CONFIG);
    localparam logic [ADDR_W-1:0] A_KEY    = ADDR_W'(ADDR_KEY);
    localparam logic [ADDR_W-1:0] A_BLOCK  = ADDR_W'(ADDR_BLOCK);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(ADDR_STATUS);
    localparam logic [ADDR_W-1:0] A_START  = ADDR_W'(ADDR_START);
    localparam logic [ADDR_W-1:0] A_RESULT = ADDR_W'(ADDR_RESULT);

    fsm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              encdec_q, encdec_d, keylen_q, keylen_d;
    logic              err_q, err_d, key_ready_q, key_ready_d, valid_q, valid_d;
    logic              init_q, init_d, next_q, next_d;
    logic [127:0]      res_q, res_d;
    logic [RP_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DOUT_W-1:0] data_out_q, data_out_d;

    logic              idle_s, cfg_wr_s, key_shift_s, blk_shift_s, sts_wr_s;
    logic              key_full_s, blk_full_s, key_ovf_s, blk_ovf_s;
    logic [KCNT_W-1:0] key_limit_s;
    logic [255:0]      key_s;
    logic [127:0]      block_s;
    logic [127:0]      res_sh_s;

    // CONFIG, KEY and BLOCK writes are only accepted while no core operation is running
    assign idle_s      = (state_q == ST_IDLE);
    assign cfg_wr_s    = idle_s && (address == A_CONFIG);
    assign key_shift_s = idle_s && (address == A_KEY);
    assign blk_shift_s = idle_s && (address == A_BLOCK);
    assign sts_wr_s    = idle_s && (address == A_STATUS);
    assign key_limit_s = (keylen_q == AES_256) ? KCNT_W'(KB256) : KCNT_W'(KB128);
    assign res_sh_s    = res_q << (32'(rd_ptr_q) * DOUT_W);

    aes_beat_shifter #(.W(256), .DIN_W(DIN_W), .CNT_W(KCNT_W)) u_key_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_i   (key_shift_s),
        .restart_i (addr_q != A_KEY),
        .limit_i   (key_limit_s),
        .din_i     (data_in),
        .data_o    (key_s),
        .full_o    (key_full_s),
        .ovf_o     (key_ovf_s)
    );

    aes_beat_shifter #(.W(128), .DIN_W(DIN_W), .CNT_W(BCNT_W)) u_blk_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_i   (blk_shift_s),
        .restart_i (addr_q != A_BLOCK),
        .limit_i   (BCNT_W'(BB)),
        .din_i     (data_in),
        .data_o    (block_s),
        .full_o    (blk_full_s),
        .ovf_o     (blk_ovf_s)
    );

    // Control FSM plus the config, flag and result-pointer next state
    always_comb begin
        state_d     = state_q;
        encdec_d    = encdec_q;
        keylen_d    = keylen_q;
        err_d       = err_q;
        key_ready_d = key_ready_q;
        valid_d     = valid_q;
        init_d      = 1'b0;
        next_d      = 1'b0;
        res_d       = res_q;
        if (address == A_RESULT) begin
            rd_ptr_d = (rd_ptr_q == RP_W'(RBEATS - 1)) ? '0 : rd_ptr_q + RP_W'(1);
        end else begin
            rd_ptr_d = '0;
        end
        if (cfg_wr_s) begin
            encdec_d    = data_in[CFG_ENCDEC_BIT];
            keylen_d    = data_in[CFG_KEYLEN_BIT];
            err_d       = 1'b0;
            key_ready_d = 1'b0;
        end else if (key_ovf_s || blk_ovf_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        if (key_shift_s) begin
            key_ready_d = 1'b0;
        end else begin
            key_ready_d = key_ready_d;
        end
        if (blk_shift_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (sts_wr_s && data_in[CTRL_INIT_BIT]) begin
                    if (key_full_s) begin
                        init_d  = 1'b1;
                        state_d = ST_KEYEXP;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sts_wr_s && data_in[CTRL_NEXT_BIT]) begin
                    if (key_ready_q && blk_full_s) begin
                        next_d  = 1'b1;
                        valid_d = 1'b0;
                        state_d = ST_CIPHER;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEYEXP: begin
                if (core_ready) begin
                    key_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_KEYEXP;
                end
            end
            ST_CIPHER: begin
                if (core_valid) begin
                    res_d    = core_result;
                    valid_d  = 1'b1;
                    rd_ptr_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_CIPHER;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read mux; its output is registered so the data for an address appears one edge later
    always_comb begin
        data_out_d = '0;
        case (address)
            A_STATUS: begin
                data_out_d[STS_ERR_BIT]   = err_q;
                data_out_d[STS_VALID_BIT] = valid_q;
                data_out_d[STS_READY_BIT] = key_ready_q;
            end
            A_START: begin
                data_out_d[START_KEYLEN_BIT]     = keylen_q;
                data_out_d[START_ENCDEC_BIT]     = encdec_q;
                data_out_d[START_KEY_FULL_BIT]   = key_full_s;
                data_out_d[START_BLOCK_FULL_BIT] = blk_full_s;
            end
            A_RESULT: data_out_d = res_sh_s[127 -: DOUT_W];
            default:  data_out_d = '0;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            encdec_q    <= 1'b0;
            keylen_q    <= 1'b0;
            err_q       <= 1'b0;
            key_ready_q <= 1'b0;
            valid_q     <= 1'b0;
            init_q      <= 1'b0;
            next_q      <= 1'b0;
            res_q       <= '0;
            rd_ptr_q    <= '0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= address;
            encdec_q    <= encdec_d;
            keylen_q    <= keylen_d;
            err_q       <= err_d;
            key_ready_q <= key_ready_d;
            valid_q     <= valid_d;
            init_q      <= init_d;
            next_q      <= next_d;
            res_q       <= res_d;
            rd_ptr_q    <= rd_ptr_d;
            data_out_q  <= data_out_d;
        end
    end

    // A 128-bit key sits in the low half of the shifter and is presented left-aligned
    assign core_key    = (keylen_q == AES_256) ? key_s : {key_s[127:0], 128'd0};
    assign core_block  = block_s;
    assign core_encdec = encdec_q;
    assign core_keylen = keylen_q;
    assign core_init   = init_q;
    assign core_next   = next_q;
    assign data_out    = data_out_q;
endmodule

// File: tb/tb_aes_host_if.sv
// Directed bench for aes_host_if: a 16/8-bit instance and a 32/32-bit instance driven with FIPS-197 style vectors.
module tb_aes_host_if;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
    localparam logic [127:0] BLK  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RES  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]   a16, a32;
    logic [15:0]  d16;
    logic [31:0]  d32;
    logic [7:0]   do16;
    logic [31:0]  do32;
    logic         enc16, kl16, init16, next16, rdy16, vld16;
    logic         enc32, kl32, init32, next32, rdy32, vld32;
    logic [255:0] key16, key32;
    logic [127:0] blk16, blk32, res16, res32;
    logic [127:0] res_exp;

    int n_cmp = 0;
    int n_mis = 0;

    aes_host_if #(.DIN_W(16), .DOUT_W(8), .ADDR_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .address(a16), .data_in(d16), .data_out(do16),
        .core_encdec(enc16), .core_keylen(kl16), .core_init(init16), .core_next(next16),
        .core_key(key16), .core_block(blk16), .core_ready(rdy16), .core_valid(vld16),
        .core_result(res16)
    );

    aes_host_if #(.DIN_W(32), .DOUT_W(32), .ADDR_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .address(a32), .data_in(d32), .data_out(do32),
        .core_encdec(enc32), .core_keylen(kl32), .core_init(init32), .core_next(next32),
        .core_key(key32), .core_block(blk32), .core_ready(rdy32), .core_valid(vld32),
        .core_result(res32)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat16(input logic [3:0] a, input logic [15:0] d);
        a16 = a;
        d16 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic beat32(input logic [3:0] a, input logic [31:0] d);
        a32 = a;
        d32 = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a16 = 4'd0; d16 = 16'd0; rdy16 = 1'b0; vld16 = 1'b0; res16 = 128'd0;
        a32 = 4'd0; d32 = 32'd0; rdy32 = 1'b0; vld32 = 1'b0; res32 = 128'd0;
        res_exp = RES;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_dout16", {248'd0, do16}, 256'd0);
        check_eq("rst_key16", key16, 256'd0);
        check_eq("rst_dout32", {224'd0, do32}, 256'd0);
        rst_n = 1'b1;

        // CONFIG then START readback
        beat16(4'd1, 16'h0003);
        beat16(4'd6, 16'h0000);
        check_eq("cfg_start", {248'd0, do16}, 256'hc);

        // AES-256 key, overflow beat, err clear
        for (int i = 0; i < 16; i++) beat16(4'd2, {8'(2*i), 8'(2*i+1)});
        check_eq("key256", key16, K256);
        beat16(4'd2, 16'hffff);
        check_eq("key_ovf_drop", key16, K256);
        beat16(4'd5, 16'h0000);
        check_eq("sts_err", {248'd0, do16}, 256'h4);
        beat16(4'd1, 16'h0003);
        beat16(4'd5, 16'h0000);
        check_eq("err_clr", {248'd0, do16}, 256'h0);
        beat16(4'd6, 16'h0000);
        check_eq("start_keyfull", {248'd0, do16}, 256'he);

        // init with an incomplete key, then a good init
        for (int i = 0; i < 15; i++) beat16(4'd2, {8'(2*i), 8'(2*i+1)});
        beat16(4'd5, 16'h0001);
        check_eq("init_blocked", {255'd0, init16}, 256'd0);
        beat16(4'd5, 16'h0000);
        check_eq("sts_err_init", {248'd0, do16}, 256'h4);
        for (int i = 0; i < 16; i++) beat16(4'd2, {8'(2*i), 8'(2*i+1)});
        beat16(4'd1, 16'h0003);
        beat16(4'd5, 16'h0001);
        check_eq("init_pulse", {255'd0, init16}, 256'd1);
        beat16(4'd1, 16'h0000);
        check_eq("init_single", {255'd0, init16}, 256'd0);
        rdy16 = 1'b1;
        beat16(4'd0, 16'h0000);
        rdy16 = 1'b0;
        beat16(4'd5, 16'h0000);
        check_eq("sts_ready", {248'd0, do16}, 256'h1);
        beat16(4'd6, 16'h0000);
        check_eq("cfg_locked", {248'd0, do16}, 256'he);

        // block load and cipher
        for (int i = 0; i < 8; i++) beat16(4'd3, {8'(34*i), 8'(34*i+17)});
        check_eq("block", {128'd0, blk16}, {128'd0, BLK});
        beat16(4'd5, 16'h0002);
        check_eq("next_pulse", {255'd0, next16}, 256'd1);
        check_eq("no_init_on_next", {255'd0, init16}, 256'd0);
        vld16 = 1'b1;
        res16 = RES;
        beat16(4'd0, 16'h0000);
        vld16 = 1'b0;
        check_eq("next_single", {255'd0, next16}, 256'd0);
        beat16(4'd5, 16'h0000);
        check_eq("sts_valid", {254'd0, do16[2:1]}, 256'h1);

        // result readout with wrap and leave-clear
        for (int i = 0; i < 16; i++) begin
            beat16(4'd7, 16'h0000);
            check_eq($sformatf("res8_b%0d", i), {248'd0, do16}, {248'd0, res_exp[127-8*i -: 8]});
        end
        beat16(4'd7, 16'h0000);
        check_eq("res8_wrap", {248'd0, do16}, 256'h8e);
        beat16(4'd0, 16'h0000);
        beat16(4'd7, 16'h0000);
        check_eq("res8_leave", {248'd0, do16}, 256'h8e);

        // block overflow sets err and a block beat drops valid
        for (int i = 0; i < 9; i++) beat16(4'd3, 16'h1234);
        beat16(4'd5, 16'h0000);
        check_eq("blk_ovf", {254'd0, do16[2:1]}, 256'h2);

        // wide instance: AES-256 in 8 beats, result in 4 beats
        beat32(4'd1, 32'h3);
        for (int i = 0; i < 8; i++) beat32(4'd2, {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
        check_eq("key256_w32", key32, K256);
        for (int i = 0; i < 4; i++) beat32(4'd3, {8'(68*i), 8'(68*i+17), 8'(68*i+34), 8'(68*i+51)});
        check_eq("block_w32", {128'd0, blk32}, {128'd0, BLK});
        beat32(4'd5, 32'h1);
        check_eq("init_w32", {255'd0, init32}, 256'd1);
        rdy32 = 1'b1;
        beat32(4'd0, 32'h0);
        rdy32 = 1'b0;
        check_eq("init_single_w32", {255'd0, init32}, 256'd0);
        beat32(4'd5, 32'h2);
        check_eq("next_w32", {255'd0, next32}, 256'd1);
        vld32 = 1'b1;
        res32 = RES;
        beat32(4'd0, 32'h0);
        vld32 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat32(4'd7, 32'h0);
            check_eq($sformatf("res32_b%0d", i), {224'd0, do32}, {224'd0, res_exp[127-32*i -: 32]});
        end
        beat32(4'd7, 32'h0);
        check_eq("res32_wrap", {224'd0, do32}, 256'h8ea2b7ca);

        // AES-128 key is presented left-aligned
        beat32(4'd1, 32'h1);
        for (int i = 0; i < 4; i++) beat32(4'd2, {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
        check_eq("key128_w32", key32, K128);
        beat32(4'd6, 32'h0);
        check_eq("start_w32", {224'd0, do32}, 256'h7);

        // asynchronous reset in the middle of a key expansion
        beat16(4'd5, 16'h0001);
        check_eq("init_before_rst", {255'd0, init16}, 256'd1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_init", {255'd0, init16}, 256'd0);
        check_eq("arst_key", key16, 256'd0);
        check_eq("arst_dout", {248'd0, do16}, 256'd0);
        check_eq("arst_cfg", {254'd0, kl16, enc16}, 256'd0);
        a16 = 4'd0;
        d16 = 16'h0000;
        #2;
        rst_n = 1'b1;
        beat16(4'd6, 16'h0000);
        check_eq("rst_start", {248'd0, do16}, 256'h0);
        beat16(4'd5, 16'h0000);
        check_eq("rst_status", {248'd0, do16}, 256'h0);
        check_eq("rst_no_init", {255'd0, init16}, 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
